// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter and drives the read address of a combinational
// instruction memory. Each fetched word goes into an output register that
// decode drains through a valid/ready handshake. The sequencer supports:
//   - sequential fetch at one instruction per cycle while decode accepts
//   - hold of the PC and the output register under back-pressure
//   - redirect: loads a word-aligned target and flushes the output register
//   - halt: stops fetching when the halt opcode is loaded
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   start          one-cycle pulse; leaves IDLE and begins fetching at RESET_PC
//   imem_ra        instruction memory read address (this is the registered PC)
//   imem_rd        instruction memory read data, valid in the same cycle
//   out_valid      out_instr / out_pc hold an instruction for decode
//   out_ready      decode accepts the presented instruction
//   out_instr      fetched instruction
//   out_pc         byte address of out_instr
//   redirect_valid load redirect_pc and flush (ignored in IDLE)
//   redirect_pc    redirect target; the low two bits are forced to zero
//   halted         sequencer is in HALT
//   fetch_count    number of loads into the output register, saturating
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int unsigned              ADDR_W     = 9,
   parameter int unsigned              DATA_W     = 32,
   parameter logic [ADDR_W-1:0]        RESET_PC   = '0,
   parameter logic [DATA_W-1:0]        HALT_INSTR = 32'h0000_0073
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_ra,
   input  logic [DATA_W-1:0] imem_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
   localparam logic [15:0]       COUNT_MAX  = 16'hFFFF;

   // Registered state
   state_t              state;
   logic [ADDR_W-1:0]   pc;

   // Next-state values
   state_t              state_nxt;
   logic [ADDR_W-1:0]   pc_nxt;
   logic                out_valid_nxt;
   logic [DATA_W-1:0]   out_instr_nxt;
   logic [ADDR_W-1:0]   out_pc_nxt;
   logic                halted_nxt;
   logic [15:0]         fetch_count_nxt;

   // Helper terms
   logic [ADDR_W-1:0]   redirect_aligned;
   logic                load_slot;
   logic                is_halt_word;

   // Masking (rather than slicing) keeps every redirect_pc bit in use
   assign redirect_aligned = redirect_pc & ALIGN_MASK;

   // The output register can take a new word when it is empty or being drained
   assign load_slot    = !out_valid || out_ready;
   assign is_halt_word = (imem_rd == HALT_INSTR);

   // The memory is addressed straight from the PC register
   assign imem_ra = pc;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         out_valid   <= 1'b0;
         out_instr   <= '0;
         out_pc      <= '0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         out_valid   <= out_valid_nxt;
         out_instr   <= out_instr_nxt;
         out_pc      <= out_pc_nxt;
         halted      <= halted_nxt;
         fetch_count <= fetch_count_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      out_valid_nxt   = out_valid;
      out_instr_nxt   = out_instr;
      out_pc_nxt      = out_pc;
      halted_nxt      = halted;
      fetch_count_nxt = fetch_count;

      unique case (state)
         ST_IDLE: begin
            // Redirects are ignored here; only start leaves IDLE
            if (start) begin
               state_nxt = ST_RUN;
               pc_nxt    = RESET_PC;
            end
         end

         ST_RUN: begin
            if (redirect_valid) begin
               // Flush wins even when decode accepts in this same cycle;
               // that word was consumed, so nothing is replayed.
               pc_nxt        = redirect_aligned;
               out_valid_nxt = 1'b0;
            end else if (load_slot) begin
               out_instr_nxt = imem_rd;
               out_pc_nxt    = pc;
               out_valid_nxt = 1'b1;
               if (fetch_count != COUNT_MAX) begin
                  fetch_count_nxt = fetch_count + 16'd1;
               end
               if (is_halt_word) begin
                  // PC stays on the halt word
                  state_nxt  = ST_HALT;
                  halted_nxt = 1'b1;
               end else begin
                  pc_nxt = pc + PC_STEP;
               end
            end
            // Otherwise back-pressured: everything holds
         end

         ST_HALT: begin
            if (redirect_valid) begin
               pc_nxt        = redirect_aligned;
               out_valid_nxt = 1'b0;
               halted_nxt    = 1'b0;
               state_nxt     = ST_RUN;
            end else if (out_valid && out_ready) begin
               out_valid_nxt = 1'b0;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. A small combinational memory model
// answers imem_ra; each scenario task drives stimulus and compares outputs
// against hand-computed values one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 32;
   localparam logic [DATA_W-1:0] HALT_W = 32'h0000_0073;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] imem_ra;
   logic [DATA_W-1:0] imem_rd;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halted;
   logic [15:0]       fetch_count;

   int unsigned compared;
   int unsigned mismatched;

   logic [DATA_W-1:0] mem [0:127];

   assign imem_rd = mem[imem_ra[8:2]];

   fetch_sequencer #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RESET_PC   (9'h000),
      .HALT_INSTR (HALT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .imem_ra        (imem_ra),
      .imem_rd        (imem_rd),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset held, then a redirect pulse in IDLE that must be ignored
   task automatic test_reset();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", out_valid); end
      compared++; if (imem_ra !== 9'h000) begin mismatched++; $display("FAIL rst_ra got %h want 000", imem_ra); end
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL rst_halted got %b want 0", halted); end
      compared++; if (fetch_count !== 16'd0) begin mismatched++; $display("FAIL rst_count got %0d want 0", fetch_count); end
      compared++; if (out_instr !== 32'h0) begin mismatched++; $display("FAIL rst_instr got %h want 0", out_instr); end
      compared++; if (out_pc !== 9'h000) begin mismatched++; $display("FAIL rst_pc got %h want 000", out_pc); end
      #6 reset = 1'b1;
      step();
      redirect_valid = 1'b1; redirect_pc = 9'h080;
      step();
      redirect_valid = 1'b0;
      step();
      compared++; if (imem_ra !== 9'h000) begin mismatched++; $display("FAIL idle_redirect_ra got %h want 000", imem_ra); end
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL idle_valid got %b want 0", out_valid); end
   endtask

   // Start, then the first two sequential loads
   task automatic test_fetch();
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      compared++; if (imem_ra !== 9'h000) begin mismatched++; $display("FAIL c1_ra got %h want 000", imem_ra); end
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL c1_valid got %b want 0", out_valid); end
      step();
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL c2_valid got %b want 1", out_valid); end
      compared++; if (out_pc !== 9'h000) begin mismatched++; $display("FAIL c2_pc got %h want 000", out_pc); end
      compared++; if (out_instr !== 32'h0000_0013) begin mismatched++; $display("FAIL c2_instr got %h want 00000013", out_instr); end
      compared++; if (fetch_count !== 16'd1) begin mismatched++; $display("FAIL c2_count got %0d want 1", fetch_count); end
      step();
      compared++; if (out_pc !== 9'h004) begin mismatched++; $display("FAIL c3_pc got %h want 004", out_pc); end
      compared++; if (out_instr !== 32'h0010_0093) begin mismatched++; $display("FAIL c3_instr got %h want 00100093", out_instr); end
      compared++; if (imem_ra !== 9'h008) begin mismatched++; $display("FAIL c3_ra got %h want 008", imem_ra); end
   endtask

   // Decode stalls for three cycles while out_pc=4
   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         compared++; if (out_pc !== 9'h004) begin mismatched++; $display("FAIL bp_pc[%0d] got %h want 004", i, out_pc); end
         compared++; if (out_instr !== 32'h0010_0093) begin mismatched++; $display("FAIL bp_instr[%0d] got %h want 00100093", i, out_instr); end
         compared++; if (imem_ra !== 9'h008) begin mismatched++; $display("FAIL bp_ra[%0d] got %h want 008", i, imem_ra); end
         compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
         compared++; if (fetch_count !== 16'd2) begin mismatched++; $display("FAIL bp_count[%0d] got %0d want 2", i, fetch_count); end
      end
      out_ready = 1'b1;
      step();
      compared++; if (out_pc !== 9'h008) begin mismatched++; $display("FAIL bp_resume_pc got %h want 008", out_pc); end
      compared++; if (out_instr !== 32'h0020_0113) begin mismatched++; $display("FAIL bp_resume_instr got %h want 00200113", out_instr); end
      compared++; if (fetch_count !== 16'd3) begin mismatched++; $display("FAIL bp_resume_count got %0d want 3", fetch_count); end
   endtask

   // Misaligned redirect with a simultaneous accepted transfer
   task automatic test_redirect();
      redirect_valid = 1'b1; redirect_pc = 9'h043;
      step();
      redirect_valid = 1'b0;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rd_flush got %b want 0", out_valid); end
      compared++; if (imem_ra !== 9'h040) begin mismatched++; $display("FAIL rd_ra got %h want 040", imem_ra); end
      compared++; if (fetch_count !== 16'd3) begin mismatched++; $display("FAIL rd_count got %0d want 3", fetch_count); end
      step();
      compared++; if (out_pc !== 9'h040) begin mismatched++; $display("FAIL rd_pc got %h want 040", out_pc); end
      compared++; if (out_instr !== 32'hA000_0040) begin mismatched++; $display("FAIL rd_instr got %h want a0000040", out_instr); end
      compared++; if (fetch_count !== 16'd4) begin mismatched++; $display("FAIL rd_count2 got %0d want 4", fetch_count); end
      step();
      compared++; if (out_pc !== 9'h044) begin mismatched++; $display("FAIL rd_next_pc got %h want 044", out_pc); end
   endtask

   // PC wrap at the top of the address space, running on into the halt word
   task automatic test_wrap();
      logic [ADDR_W-1:0] exp_pc [0:6];
      exp_pc[0] = 9'h1F8; exp_pc[1] = 9'h1FC; exp_pc[2] = 9'h000; exp_pc[3] = 9'h004;
      exp_pc[4] = 9'h008; exp_pc[5] = 9'h00C; exp_pc[6] = 9'h010;
      redirect_valid = 1'b1; redirect_pc = 9'h1F8;
      step();
      redirect_valid = 1'b0;
      compared++; if (imem_ra !== 9'h1F8) begin mismatched++; $display("FAIL wr_ra got %h want 1f8", imem_ra); end
      for (int i = 0; i < 7; i++) begin
         step();
         compared++; if (out_pc !== exp_pc[i]) begin mismatched++; $display("FAIL wr_pc[%0d] got %h want %h", i, out_pc, exp_pc[i]); end
         compared++; if (fetch_count !== 16'(6 + i)) begin mismatched++; $display("FAIL wr_count[%0d] got %0d want %0d", i, fetch_count, 6 + i); end
      end
      compared++; if (out_instr !== 32'h0000_0013 && out_pc === 9'h000) begin mismatched++; $display("FAIL wr_instr got %h want 00000013", out_instr); end
   endtask

   // Halt word presented at 0x010, drained, then redirect out of HALT
   task automatic test_halt();
      compared++; if (out_instr !== HALT_W) begin mismatched++; $display("FAIL h_instr got %h want 00000073", out_instr); end
      compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL h_halted got %b want 1", halted); end
      compared++; if (imem_ra !== 9'h010) begin mismatched++; $display("FAIL h_ra got %h want 010", imem_ra); end
      out_ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL h_hold_valid got %b want 1", out_valid); end
      compared++; if (fetch_count !== 16'd12) begin mismatched++; $display("FAIL h_hold_count got %0d want 12", fetch_count); end
      compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL h_start_ignored got %b want 1", halted); end
      out_ready = 1'b1;
      step();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL h_drain_valid got %b want 0", out_valid); end
      step();
      compared++; if (fetch_count !== 16'd12) begin mismatched++; $display("FAIL h_noload_count got %0d want 12", fetch_count); end
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL h_noload_valid got %b want 0", out_valid); end
      redirect_valid = 1'b1; redirect_pc = 9'h020;
      step();
      redirect_valid = 1'b0;
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL h_exit_halted got %b want 0", halted); end
      compared++; if (imem_ra !== 9'h020) begin mismatched++; $display("FAIL h_exit_ra got %h want 020", imem_ra); end
      step();
      compared++; if (out_pc !== 9'h020) begin mismatched++; $display("FAIL h_exit_pc got %h want 020", out_pc); end
      compared++; if (out_instr !== 32'hA000_0020) begin mismatched++; $display("FAIL h_exit_instr got %h want a0000020", out_instr); end
      compared++; if (fetch_count !== 16'd13) begin mismatched++; $display("FAIL h_exit_count got %0d want 13", fetch_count); end
   endtask

   // Reset asserted between clock edges while an instruction is valid
   task automatic test_async_reset();
      #3 reset = 1'b0;
      #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL ar_valid got %b want 0", out_valid); end
      compared++; if (imem_ra !== 9'h000) begin mismatched++; $display("FAIL ar_ra got %h want 000", imem_ra); end
      compared++; if (fetch_count !== 16'd0) begin mismatched++; $display("FAIL ar_count got %0d want 0", fetch_count); end
      reset = 1'b1;
      step();
      step();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL ar_idle_valid got %b want 0", out_valid); end
      compared++; if (imem_ra !== 9'h000) begin mismatched++; $display("FAIL ar_idle_ra got %h want 000", imem_ra); end
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL ar_restart_valid got %b want 1", out_valid); end
      compared++; if (out_pc !== 9'h000) begin mismatched++; $display("FAIL ar_restart_pc got %h want 000", out_pc); end
      compared++; if (fetch_count !== 16'd1) begin mismatched++; $display("FAIL ar_restart_count got %0d want 1", fetch_count); end
   endtask

   // fetch_count saturates at 16'hFFFF under continuous fetch
   task automatic test_saturate();
      mem[4] = 32'h0000_0013;
      repeat (65536) @(posedge clk);
      #1;
      compared++; if (fetch_count !== 16'hFFFF) begin mismatched++; $display("FAIL sat_count got %h want ffff", fetch_count); end
      step();
      compared++; if (fetch_count !== 16'hFFFF) begin mismatched++; $display("FAIL sat_hold got %h want ffff", fetch_count); end
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL sat_valid got %b want 1", out_valid); end
   endtask

   initial begin
      compared       = 0;
      mismatched     = 0;
      reset          = 1'b0;
      start          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093;
      mem[2] = 32'h0020_0113;
      mem[4] = HALT_W;
      #6;
      test_reset();
      test_fetch();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_async_reset();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the read address of instructionmemory and presents fetched instructions to the decode stage through a valid/ready handshake.
- Owns the program counter: sequential fetch, branch/jump redirect with flush, back-pressure hold, and halt on a halt opcode.
- instructionmemory reads combinationally: rd is valid in the same cycle as ra.

Parameters:
ADDR_W, 9, width of instruction byte address (matches instructionmemory ra)
DATA_W, 32, instruction width
RESET_PC, 9'h000, first fetch address after start
HALT_INSTR, 32'h0000_0073, opcode that stops sequential fetch

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
start  in  1  single-cycle pulse; begins fetching from RESET_PC when IDLE
imem_ra  out  ADDR_W  read address to instructionmemory.ra
imem_rd  in  DATA_W  read data from instructionmemory.rd
out_valid  out  1  out_instr/out_pc hold a valid instruction
out_ready  in  1  decode accepts; transfer when out_valid && out_ready
out_instr  out  DATA_W  fetched instruction
out_pc  out  ADDR_W  address of out_instr
redirect_valid  in  1  load redirect_pc and flush
redirect_pc  in  ADDR_W  redirect target
halted  out  1  sequencer is in HALT
fetch_count  out  16  instructions loaded into output register, saturating

Behaviour:
- Reset (async, reset=0): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0. All take effect immediately, including mid-operation.
- imem_ra = pc (registered PC, no extra logic).
- States are IDLE, RUN, HALT.
- IDLE:
  - start=1 -> RUN next cycle.
  - redirect_valid is ignored.
  - No loads.
- RUN, priority order:
  1. redirect_valid=1: pc <= {redirect_pc[ADDR_W-1:2],2'b00}; out_valid <= 0 (flush, regardless of out_ready); no load; fetch_count unchanged.
  2. load condition (!out_valid || out_ready): out_instr <= imem_rd, out_pc <= pc, out_valid <= 1, fetch_count += 1 (saturates at 16'hFFFF).
     - If imem_rd == HALT_INSTR: pc unchanged, state -> HALT, halted <= 1.
     - Otherwise pc <= pc + 4, modulo 2^ADDR_W (9'h1FC -> 9'h000).
  3. out_valid && !out_ready: hold pc, out_instr, out_pc, out_valid stable.
- HALT:
  - No loads.
  - Held output stays valid until accepted, then out_valid <= 0.
  - redirect_valid=1: pc <= aligned redirect_pc, out_valid <= 0, halted <= 0, state -> RUN.
  - start is ignored.
- start is ignored in RUN.
- Latency:
  - start sampled at cycle 0 -> RUN and imem_ra=RESET_PC at cycle 1 -> out_valid=1 with instr@RESET_PC at cycle 2.
  - Redirect sampled at N -> imem_ra=target at N+1 -> target instr valid at N+2.
- Throughput is 1 instruction/cycle with out_ready held 1.
- Simultaneous redirect and accepted transfer: the consumer has taken the instruction; the sequencer still flushes, and there is no duplicate or replay.
- Misaligned redirect: low two bits are forced to 0.

Test Plan:
- Reset then start, out_ready=1, memory words 0x00000013 @0, 0x00100093 @4, 0x00200113 @8 -> out_valid rises at cycle 2; out_pc sequence 0,4,8 on consecutive cycles with matching out_instr; fetch_count=3 after three loads.
- Back-pressure: drop out_ready for 3 cycles while out_pc=4 -> out_pc=4, out_instr, imem_ra=8 stay stable for 3 cycles; out_pc=8 appears the cycle after out_ready returns; no skipped or duplicated addresses.
- Redirect: redirect_valid with redirect_pc=9'h043 while out_pc=8 -> next cycle out_valid=0 and imem_ra=0x040; following cycle out_pc=0x040.
- Wrap: redirect to 0x1F8 -> out_pc 0x1F8, 0x1FC, 0x000.
- Halt: HALT_INSTR at 0x010 -> out_pc=0x010 presented, halted=1, no further loads; after acceptance out_valid=0; redirect to 0x020 -> halted=0, out_pc=0x020 two cycles later.
- Async reset mid-run with out_valid=1: reset=0 between clock edges -> out_valid=0, imem_ra=RESET_PC, fetch_count=0 immediately; start is required again to resume.
